// File: rtl/awgn_clt_gen.sv
// Multi-channel Gaussian noise source: sums SUM_N xorshift32 uniforms
// per channel (central limit), removes the mean, scales by sigma.
module awgn_clt_gen #(
  parameter int NUM_CH = 2,
  parameter int OUT_W  = 16,
  parameter int UW     = 12,
  parameter int LOG2_N = 4,
  parameter int SIG_W  = 8,
  parameter int SHIFT  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             seed1,
  input  logic [31:0]             seed2,
  input  logic                    load,
  input  logic                    en,
  input  logic [SIG_W-1:0]        sigma,
  input  logic                    out_ready,
  output logic                    v,
  output logic [NUM_CH*OUT_W-1:0] x,
  output logic [NUM_CH-1:0]       sat
);

  localparam int ACC_W = UW + LOG2_N;
  localparam int P_W   = ACC_W + SIG_W + 2;
  localparam int SUM_N = 1 << LOG2_N;

  localparam logic signed [P_W-1:0] MAXV =
    {{(P_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [P_W-1:0] MINV =
    {{(P_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ACC,
    SCALE,
    HOLD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]      r_s   [NUM_CH];
  logic [ACC_W-1:0] r_acc [NUM_CH];
  logic [LOG2_N-1:0] r_cnt;

  logic [31:0] w_seed [NUM_CH];
  logic [31:0] w_step [NUM_CH];

  logic [NUM_CH*OUT_W-1:0] w_x;
  logic [NUM_CH-1:0]       w_sat;

  logic w_wr;
  logic w_last;
  logic w_step_en;
  logic w_load_out;

  function automatic logic [31:0] f_xs(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [31:0]             w_raw;
    logic signed [ACC_W:0]   w_c;
    logic signed [P_W-1:0]   w_ce;
    logic signed [P_W-1:0]   w_se;
    logic signed [P_W-1:0]   w_p;
    logic signed [P_W-1:0]   w_r;
    logic                    w_hi;
    logic                    w_lo;

    assign w_raw     = seed1 + seed2 * 32'(g);
    assign w_seed[g] = (w_raw == '0) ? 32'h1 : w_raw;
    assign w_step[g] = f_xs(r_s[g]);

    // Offset-binary sum to signed: subtract the mean 2^(ACC_W-1).
    assign w_c  = $signed({1'b0, r_acc[g]})
                - $signed({2'b01, {(ACC_W-1){1'b0}}});
    assign w_ce = P_W'(w_c);
    assign w_se = P_W'($signed({1'b0, sigma}));
    assign w_p  = w_ce * w_se;
    assign w_r  = w_p >>> SHIFT;

    assign w_hi = (w_r > MAXV);
    assign w_lo = (w_r < MINV);

    assign w_x[g*OUT_W +: OUT_W] =
      w_hi ? MAXV[OUT_W-1:0] :
      w_lo ? MINV[OUT_W-1:0] :
             w_r[OUT_W-1:0];
    assign w_sat[g] = w_hi | w_lo;
  end

  assign w_wr   = !v || out_ready;
  assign w_last = (r_cnt == LOG2_N'(SUM_N - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_step_en   = 1'b0;
    w_load_out  = 1'b0;
    unique case (r_state)
      ACC: begin
        if (en) begin
          w_step_en = 1'b1;
          if (w_last) w_state_nxt = SCALE;
        end
      end
      SCALE, HOLD: begin
        if (w_wr) begin
          w_load_out  = 1'b1;
          w_state_nxt = ACC;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: w_state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACC;
      r_cnt   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_s[c]   <= w_seed[c];
        r_acc[c] <= '0;
      end
      v   <= 1'b0;
      x   <= '0;
      sat <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (load) begin
        r_state <= ACC;
        r_cnt   <= '0;
        for (int c = 0; c < NUM_CH; c++) begin
          r_s[c]   <= w_seed[c];
          r_acc[c] <= '0;
        end
      end else if (w_step_en) begin
        r_cnt <= r_cnt + 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
          r_s[c]   <= w_step[c];
          r_acc[c] <= r_acc[c] + ACC_W'(r_s[c][31 -: UW]);
        end
      end else if (w_load_out) begin
        r_cnt <= '0;
        for (int c = 0; c < NUM_CH; c++) begin
          r_acc[c] <= '0;
        end
      end
      // A re-seed never disturbs the output register.
      if (w_load_out && !load) begin
        v   <= 1'b1;
        x   <= w_x;
        sat <= w_sat;
      end else if (v && out_ready) begin
        v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_awgn_clt_gen.sv
// Bench for awgn_clt_gen: default instance plus a SHIFT=0 instance,
// checked against a per-vector CLT reference model.
module tb_awgn_clt_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic        en;
  logic        out_ready;
  logic [31:0] seed1;
  logic [31:0] seed2;
  logic [7:0]  sigma;

  logic        v1, v2;
  logic [31:0] x1, x2;
  logic [1:0]  sat1, sat2;

  int errors = 0;
  int checks = 0;

  logic [31:0] e1x [64];
  logic [31:0] e2x [64];
  logic [1:0]  e1s [64];
  logic [1:0]  e2s [64];
  int          idxq [$];

  logic        same_chk;
  logic        changed;
  logic [31:0] first_x;
  logic        have_first;

  awgn_clt_gen u_dut (
    .clk(clk), .reset(reset), .seed1(seed1), .seed2(seed2),
    .load(load), .en(en), .sigma(sigma), .out_ready(out_ready),
    .v(v1), .x(x1), .sat(sat1)
  );

  awgn_clt_gen #(.SHIFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .seed1(seed1), .seed2(seed2),
    .load(load), .en(en), .sigma(sigma), .out_ready(out_ready),
    .v(v2), .x(x2), .sat(sat2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xs(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

  task automatic sc(input longint p, input int sh,
                    output logic [15:0] xo, output logic so);
    longint r;
    r = p >>> sh;
    if (r > 32767) begin
      xo = 16'h7FFF; so = 1'b1;
    end else if (r < -32768) begin
      xo = 16'h8000; so = 1'b1;
    end else begin
      xo = r[15:0]; so = 1'b0;
    end
  endtask

  // Vector k = sum of 16 consecutive 12-bit draws per channel, centred and scaled.
  task automatic gen(input logic [31:0] a, input logic [31:0] b,
                     input logic [7:0] sg, input int n);
    logic [31:0] s [2];
    int          sum;
    longint      p;
    logic [15:0] xo;
    logic        so;
    for (int c = 0; c < 2; c++) begin
      s[c] = a + b * 32'(c);
      if (s[c] == 32'h0) s[c] = 32'h1;
    end
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < 2; c++) begin
        sum = 0;
        for (int i = 0; i < 16; i++) begin
          sum += int'(s[c][31:20]);
          s[c] = xs(s[c]);
        end
        p = (longint'(sum) - 32768) * longint'({56'd0, sg});
        sc(p, 8, xo, so);
        e1x[k][c*16 +: 16] = xo;
        e1s[k][c] = so;
        sc(p, 0, xo, so);
        e2x[k][c*16 +: 16] = xo;
        e2s[k][c] = so;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] sg, input logic ory);
    seed1 = a; seed2 = b; sigma = sg;
    out_ready = ory; en = 1'b1; load = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_v", 64'(v1), 64'(0));
      chk("rst_x", 64'(x1), 64'(0));
      chk("rst_sat", 64'({sat1, sat2}), 64'(0));
    end
    reset = 1'b0;
  endtask

  // Compare every transfer against the queued model indices.
  task automatic collect(input string tag, input logic rand_en);
    int guard;
    int k;
    guard = 0;
    while (idxq.size() > 0) begin
      if (v1 && out_ready) begin
        k = idxq.pop_front();
        chk({tag, "_x"}, 64'(x1), 64'(e1x[k]));
        chk({tag, "_sat"}, 64'(sat1), 64'(e1s[k]));
        chk({tag, "_x0"}, 64'(x2), 64'(e2x[k]));
        chk({tag, "_sat0"}, 64'(sat2), 64'(e2s[k]));
        if (same_chk) begin
          chk({tag, "_same"}, 64'(x1[15:0]), 64'(x1[31:16]));
          if (!have_first) begin
            first_x = x1; have_first = 1'b1;
          end else if (x1 != first_x) begin
            changed = 1'b1;
          end
        end
        guard = 0;
      end
      if (rand_en) en = 1'($urandom_range(0, 1));
      tick();
      guard++;
      if (guard > 300) begin
        chk({tag, "_timeout"}, 64'(1), 64'(0));
        idxq.delete();
      end
    end
    en = 1'b1;
  endtask

  logic [31:0] ra, rb;
  logic [7:0]  rs;

  initial begin
    same_chk = 1'b0; changed = 1'b0; have_first = 1'b0; first_x = '0;
    reset = 1'b1; load = 1'b0; en = 1'b1; out_ready = 1'b1;
    seed1 = '0; seed2 = '0; sigma = '0;

    // Free-running: v every 17 cycles, vectors bit-exact.
    rs = 8'($urandom_range(1, 255));
    gen(32'h67580, 32'h70385, rs, 8);
    do_reset(32'h67580, 32'h70385, rs, 1'b1);
    for (int cyc = 1; cyc <= 51; cyc++) begin
      tick();
      chk("v_period", 64'(v1), 64'((cyc % 17) == 0));
      if ((cyc % 17) == 0) begin
        chk("run_x", 64'(x1), 64'(e1x[cyc/17 - 1]));
        chk("run_sat", 64'(sat1), 64'(e1s[cyc/17 - 1]));
        chk("run_x0", 64'(x2), 64'(e2x[cyc/17 - 1]));
      end
    end

    // Backpressure: output holds, then sequence resumes unchanged.
    do_reset(32'h67580, 32'h70385, rs, 1'b0);
    for (int cyc = 1; cyc <= 57; cyc++) begin
      tick();
      if (cyc >= 17) begin
        chk("hold_v", 64'(v1), 64'(1));
        chk("hold_x", 64'(x1), 64'(e1x[0]));
      end
    end
    out_ready = 1'b1;
    idxq = {0, 1, 2, 3};
    collect("bp", 1'b0);

    // sigma = 0 gives silence.
    ra = $urandom; rb = $urandom;
    gen(ra, rb, 8'h00, 3);
    do_reset(ra, rb, 8'h00, 1'b1);
    idxq = {0, 1, 2};
    collect("sig0", 1'b0);

    // Zero seeds collapse to state 1 on every channel.
    gen(32'h0, 32'h0, 8'h40, 10);
    do_reset(32'h0, 32'h0, 8'h40, 1'b1);
    same_chk = 1'b1;
    idxq = {0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    collect("zseed", 1'b0);
    same_chk = 1'b0;
    chk("zseed_nonconst", 64'(changed), 64'(1));

    // Full-scale sigma exercises saturation on the SHIFT=0 instance.
    gen(32'h1234_5678, 32'h9E37_79B9, 8'hFF, 5);
    do_reset(32'h1234_5678, 32'h9E37_79B9, 8'hFF, 1'b1);
    idxq = {0, 1, 2, 3, 4};
    collect("satur", 1'b0);

    // Random seeds, sigma and enable gaps.
    ra = $urandom; rb = $urandom;
    rs = 8'($urandom);
    gen(ra, rb, rs, 6);
    do_reset(ra, rb, rs, 1'b1);
    idxq = {0, 1, 2, 3, 4, 5};
    collect("rnd_en", 1'b1);

    // Re-seed mid-accumulation with an output pending.
    gen(32'h67580, 32'h70385, 8'h40, 4);
    do_reset(32'h67580, 32'h70385, 8'h40, 1'b0);
    for (int i = 0; i < 17; i++) tick();
    chk("ld_pend_v", 64'(v1), 64'(1));
    for (int i = 0; i < 7; i++) tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("ld_keep_v", 64'(v1), 64'(1));
    chk("ld_keep_x", 64'(x1), 64'(e1x[0]));
    out_ready = 1'b1;
    idxq = {0, 0, 1, 2};
    collect("load", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
